// File: rtl/present_inv_sbox_dom_d1.sv
// First-order DOM-indep masked PRESENT inverse S-box, built as quadratic layer G then layer F.
// Latency: 3 cycles with PRESENT_INV_SBOX_OUT_REG_EN defined, 2 cycles without it.
// Backpressure: none; accepts a nibble every cycle and has no stall input.
module present_inv_sbox_dom_d1 (
  input  logic clock_0,
  input  logic reset_0,
  input  logic in_valid,
  input  logic io_i0_s0,
  input  logic io_i1_s0,
  input  logic io_i2_s0,
  input  logic io_i3_s0,
  input  logic io_i0_s1,
  input  logic io_i1_s1,
  input  logic io_i2_s1,
  input  logic io_i3_s1,
  input  logic p_rand_0,
  input  logic p_rand_1,
  input  logic p_rand_2,
  input  logic p_rand_3,
  input  logic p_rand_4,
  input  logic p_rand_5,
  input  logic p_rand_6,
  input  logic p_rand_7,
  output logic out_valid,
  output logic io_o0_s0,
  output logic io_o1_s0,
  output logic io_o2_s0,
  output logic io_o3_s0,
  output logic io_o0_s1,
  output logic io_o1_s1,
  output logic io_o2_s1,
  output logic io_o3_s1
);

`ifdef PRESENT_INV_SBOX_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  // Unmasked view: y0 = 1^a0^a2^a1a3, y1 = a0^a1^a3^q^r^a0(a2^p^q^r),
  // y2 = 1^a3^p^q^s^a0(a2^a3^p^q^r), y3 = a0^a1^a2^a3^s^a0(p^r)
  // with G products p=a1a2, q=a1a3, r=a2a3, s=a0a1.
  // Linear part of layer F for one share; the constant 1 goes into share 0 only.
  function automatic logic [3:0] lin_terms(input logic [3:0] n, input logic [3:0] g,
                                           input logic c);
    lin_terms = {n[0] ^ n[1] ^ n[2] ^ n[3] ^ g[3],
                 c ^ n[3] ^ g[0] ^ g[1] ^ g[3],
                 n[0] ^ n[1] ^ n[3] ^ g[1] ^ g[2],
                 c ^ n[0] ^ n[2]};
  endfunction

  logic [3:0] in_sh0, in_sh1, rnd_g, rnd_f;
  assign in_sh0 = {io_i3_s0, io_i2_s0, io_i1_s0, io_i0_s0};
  assign in_sh1 = {io_i3_s1, io_i2_s1, io_i1_s1, io_i0_s1};
  assign rnd_g  = {p_rand_3, p_rand_2, p_rand_1, p_rand_0};
  assign rnd_f  = {p_rand_7, p_rand_6, p_rand_5, p_rand_4};

  // Layer G multiplier operands, bit k = multiplier k: {s, r, q, p}
  logic [3:0] ga0, gb0, ga1, gb1;
  assign ga0 = {in_sh0[0], in_sh0[2], in_sh0[1], in_sh0[1]};
  assign gb0 = {in_sh0[1], in_sh0[3], in_sh0[3], in_sh0[2]};
  assign ga1 = {in_sh1[0], in_sh1[2], in_sh1[1], in_sh1[1]};
  assign gb1 = {in_sh1[1], in_sh1[3], in_sh1[3], in_sh1[2]};

  logic [3:0] g_in0_q, g_in1_q, g_cr0_q, g_cr1_q;
  logic [3:0] nib0_q, nib1_q, rnd_f_q;

  // Layer G register: DOM inner/refreshed cross terms, plus share and layer-F randomness delay
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      g_in0_q <= '0;
      g_in1_q <= '0;
      g_cr0_q <= '0;
      g_cr1_q <= '0;
      nib0_q  <= '0;
      nib1_q  <= '0;
      rnd_f_q <= '0;
    end else begin
      g_in0_q <= ga0 & gb0;
      g_in1_q <= ga1 & gb1;
      g_cr0_q <= (ga0 & gb1) ^ rnd_g;
      g_cr1_q <= (ga1 & gb0) ^ rnd_g;
      nib0_q  <= in_sh0;
      nib1_q  <= in_sh1;
      rnd_f_q <= rnd_f;
    end
  end

  // Recombined G outputs per share domain: {s, r, q, p}
  logic [3:0] g0, g1;
  assign g0 = g_in0_q ^ g_cr0_q;
  assign g1 = g_in1_q ^ g_cr1_q;

  // Layer F operands, bit k = multiplier k: {a1*a3, a0*(p^r), a0*(a2^a3^p^q^r), a0*(a2^p^q^r)}
  logic [3:0] fa0, fb0, fa1, fb1;
  assign fa0 = {nib0_q[1], nib0_q[0], nib0_q[0], nib0_q[0]};
  assign fb0 = {nib0_q[3], g0[0] ^ g0[2],
                nib0_q[2] ^ nib0_q[3] ^ g0[0] ^ g0[1] ^ g0[2],
                nib0_q[2] ^ g0[0] ^ g0[1] ^ g0[2]};
  assign fa1 = {nib1_q[1], nib1_q[0], nib1_q[0], nib1_q[0]};
  assign fb1 = {nib1_q[3], g1[0] ^ g1[2],
                nib1_q[2] ^ nib1_q[3] ^ g1[0] ^ g1[1] ^ g1[2],
                nib1_q[2] ^ g1[0] ^ g1[1] ^ g1[2]};

  logic [3:0] f_in0_q, f_in1_q, f_cr0_q, f_cr1_q, lin0_q, lin1_q;

  // Layer F register: DOM terms plus per-share linear terms aligned with them
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      f_in0_q <= '0;
      f_in1_q <= '0;
      f_cr0_q <= '0;
      f_cr1_q <= '0;
      lin0_q  <= '0;
      lin1_q  <= '0;
    end else begin
      f_in0_q <= fa0 & fb0;
      f_in1_q <= fa1 & fb1;
      f_cr0_q <= (fa0 & fb1) ^ rnd_f_q;
      f_cr1_q <= (fa1 & fb0) ^ rnd_f_q;
      lin0_q  <= lin_terms(nib0_q, g0, 1'b1);
      lin1_q  <= lin_terms(nib1_q, g1, 1'b0);
    end
  end

  // Output shares: each bit is its linear term plus one F product
  logic [3:0] f0, f1, res0, res1, out0, out1;
  assign f0   = f_in0_q ^ f_cr0_q;
  assign f1   = f_in1_q ^ f_cr1_q;
  assign res0 = lin0_q ^ {f0[2], f0[1], f0[0], f0[3]};
  assign res1 = lin1_q ^ {f1[2], f1[1], f1[0], f1[3]};

`ifdef PRESENT_INV_SBOX_OUT_REG_EN
  logic [3:0] out0_q, out1_q;

  // Output register stage
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      out0_q <= res0;
      out1_q <= res1;
    end
  end

  assign out0 = out0_q;
  assign out1 = out1_q;
`else
  assign out0 = res0;
  assign out1 = res1;
`endif

  logic [LAT-1:0] vld_q;

  // Valid shift register tracking each nibble through the pipeline
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) vld_q <= '0;
    else          vld_q <= {vld_q[LAT-2:0], in_valid};
  end

  assign out_valid = vld_q[LAT-1];
  assign {io_o3_s0, io_o2_s0, io_o1_s0, io_o0_s0} = out0;
  assign {io_o3_s1, io_o2_s1, io_o1_s1, io_o0_s1} = out1;

endmodule

// File: doc/present_inv_sbox_dom_d1.md
PRESENT_INV_SBOX_DOM_D1 -- requirements
Module: present_inv_sbox_dom_d1

Interface
REQ-001 SHALL: clock_0  input  1  single clock; all flops are rising-edge.
REQ-002 SHALL: reset_0  input  1  asynchronous, active-low reset (low = reset).
REQ-003 SHALL: in_valid  input  1  high marks a valid masked nibble on io_i* this cycle.
REQ-004 SHALL: io_i0_s0..io_i3_s0 / io_i0_s1..io_i3_s1  input  1 each  share 0 / share 1 of ciphertext nibble bits 0..3 (i0 = LSB).
REQ-005 SHALL: p_rand_0..p_rand_7  input  1 each  fresh uniform randomness, sampled in the same cycle as in_valid.
REQ-006 SHALL: out_valid  output  1  high marks valid shares on io_o*.
REQ-007 SHALL: io_o0_s0..io_o3_s0 / io_o0_s1..io_o3_s1  output  1 each  share 0 / share 1 of the inverse S-box result bits 0..3.

Function
REQ-008 SHALL: (io_o*_s0 XOR io_o*_s1) equal PRESENT S^-1 of (io_i*_s0 XOR io_i*_s1); table x=0..F -> 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-009 SHALL: S^-1 is computed as two quadratic layers G then F; each layer uses first-order DOM-indep multipliers only.
REQ-010 SHALL: each DOM multiplier consumes one p_rand bit, with layer G using p_rand_0..3 and layer F using p_rand_4..7; no bit is reused within one nibble.
REQ-011 SHALL: each DOM cross-domain term is XORed with its random bit and registered before being recombined with the inner-domain term.
REQ-012 SHALL: layer-F randomness and any share-linear terms bypassing a DOM stage are delayed by pipeline registers to stay aligned with their nibble.
REQ-013 SHALL: no combinational path mixes share 0 and share 1 without the register of REQ-011 in between.
REQ-014 SHALL: the pipeline is fully pipelined, accepting in_valid every cycle with no backpressure and no stall input.
REQ-015 SHALL: latency L = 3 cycles (layer-G register, layer-F register, output register); out_valid follows in_valid by exactly L cycles through a valid shift register.
REQ-016 SHALL: a nibble's outputs hold for exactly one cycle; back-to-back inputs produce back-to-back outputs in issue order.
REQ-017 SHALL: share and randomness registers advance every cycle regardless of in_valid; io_o* is don't-care while out_valid is low.

Reset
REQ-018 SHALL: while reset_0 is low, out_valid, every io_o* output and every internal flop are 0, asynchronously.
REQ-019 SHALL: asserting reset mid-flight discards all in-flight nibbles, so out_valid stays low until L cycles after the first post-reset in_valid.
REQ-020 SHALL: on reset release, the first in_valid sampled on the first rising edge with reset_0 high is accepted.

Configuration
REQ-021 SHALL: with macro PRESENT_INV_SBOX_OUT_REG_EN defined, the output register stage is present and L = 3.
REQ-022 SHALL: without PRESENT_INV_SBOX_OUT_REG_EN, the output register is removed, L = 2, and io_o* is the XOR of layer-F registers driven directly; REQ-008..REQ-014 still hold.

Verification
REQ-023 SHALL: reset_0 low for 2 cycles with random inputs -> out_valid = 0 and all io_o* = 0 throughout.
REQ-024 SHALL: single nibble x=0x0 with shares s0=0x3, s1=0x3 and p_rand=0xA5 -> out_valid high exactly in cycle L with unmasked output 0x5.
REQ-025 SHALL: 16 back-to-back nibbles x=0..F with random masks and randomness -> 16 consecutive out_valid cycles unmasking to 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-026 SHALL: x=0xB held with all 256 p_rand values and random masks -> every unmasked output = 0x3.
REQ-027 SHALL: issue 3 nibbles, then pull reset_0 low one cycle later -> none of the 3 results appears, out_valid = 0 until a new input, and a new nibble x=0x7 unmasks to 0xD.
REQ-028 SHALL: rerun REQ-024 and REQ-025 with and without PRESENT_INV_SBOX_OUT_REG_EN -> latency 3 and 2 respectively, with identical unmasked results.
